hazard_ctl: RTL and testbench
=============================

# hazard_ctl

Parametrised hazard, forwarding and stall controller for the in-order RV64I hart. It keeps a shadow pipeline of destination and kind records for EX, the LD_LAT memory stages and WB. From these it computes per-operand forwarding selects for the ID stage, detects load-use and no-bypass hazards, and arbitrates cache-wait, hazard and redirect stalls into per-stage stall, bubble and flush controls. This replaces the fixed 5-stage stall logic with one block that is configurable in memory depth and forwarding mode and that keeps hazard statistics.

## Interface
- LD_LAT, 1: number of memory stages after EX; legal range 1..3. Shadow depth is D = LD_LAT+2.
- FWD_EN, 1: 1 enables bypassing; 0 stalls every dependence until the producer retires.
- FWD_W, $clog2(D+1): width of each forwarding select.
- CNT_W, 32: width of the hazard counter.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- id_ir  in  32  instruction currently in ID.
- id_valid  in  1  ID holds a real instruction (not a flushed NOP).
- imem_busy  in  1  L1i miss in progress.
- dmem_busy  in  1  L1d miss or writeback in progress.
- redirect  in  1  branch mispredict or jalr taken, resolved in ID.
- stall_if, stall_pd, stall_id  out  1  hold the IF, PD and ID pipeline registers.
- stall_be  out  1  hold all backend registers (EX..WB).
- bubble_pd  out  1  load a NOP (0x13) into the IF/PD register.
- bubble_ex  out  1  load a NOP into the ID/EX register.
- flush_fe  out  1  load NOPs into the IF/PD and PD/ID registers.
- fwd_a, fwd_b  out  FWD_W  rs1/rs2 source: 0 = regfile, k = shadow slot k.
- hz_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Decode of id_ir:
  - rs1 is used for OP, OP-IMM, OP-32, OP-IMM-32, LOAD, STORE, BRANCH and JALR.
  - rs2 is used for OP, OP-32, STORE and BRANCH.
  - wen is set for LUI, AUIPC, JAL, JALR, OP, OP-IMM, OP-32, OP-IMM-32 and LOAD, and only when rd≠0.
  - is_load is set for LOAD.
  - A source register of x0 never matches anything.
- Shadow slots S[1..D] each hold {valid, wen, rd, is_load}. S[1]=EX, S[2..LD_LAT+1]=MEM, S[D]=WB.
- Match search: for each used source, k is the smallest slot with valid & wen & rd==rs. With no match, fwd=0.
- Forwarding mode (FWD_EN=1):
  - Hazard when the match is in a slot with S[k].is_load and k≤LD_LAT. Otherwise fwd=k.
  - A slot-1 match means the hart's live ALU output. Slot D covers the regfile's lack of write-through.
- No-bypass mode (FWD_EN=0): any match is a hazard, and fwd stays 0.
- Priority: dmem_busy > hazard > redirect > imem_busy.
  - dmem_busy: all stall outputs are 1; no bubble or flush; the shadow holds.
  - hazard: stall_if/pd/id=1 and bubble_ex=1. The shadow advances with S[1] invalid. redirect is ignored this cycle, because branch operands are stale.
  - redirect: flush_fe=1 and stalls are 0. The branch in ID advances into S[1].
  - imem_busy alone: stall_if=1 and bubble_pd=1; PD, ID and the backend advance.
- Shadow advance (all cases except dmem_busy): S[1] ← decode(id_ir) with valid=id_valid & !hazard, and S[k] ← S[k-1].
- hz_cnt increments on every hazard cycle and saturates at all-ones. It does not increment during dmem_busy.

## Timing
- Reset: all S[k].valid=0 and hz_cnt=0. Every stall, bubble and flush output is 0, and fwd_a/fwd_b=0, combinationally from the cleared state. rst_n dominates all inputs, including during an active dmem_busy.
- All outputs except hz_cnt are combinational from the shadow state and the current inputs. The shadow and hz_cnt update on the rising clk edge.
- Load-use penalty is LD_LAT cycles with FWD_EN=1. An ALU dependence costs 0 cycles.
- With FWD_EN=0, a producer at slot k costs D-k+1 stall cycles.
- dmem_busy arriving during a hazard freezes the hazard: the stall persists and hz_cnt does not count. The hazard resumes and counts after dmem_busy drops.
- Multiple matches always resolve to the youngest writer, i.e. the smallest k.

## Test plan
- Reset, then idle with id_ir=0x13: all outputs 0, hz_cnt=0, fwd_a=fwd_b=0.
- LD_LAT=1, FWD_EN=1; `add x5,x1,x2` followed by `sub x6,x5,x5` → fwd_a=fwd_b=1 with no stall. A third instruction `or x7,x5,x0` → fwd_a=2, fwd_b=0.
- `ld x5,0(x1)` followed by `add x6,x5,x1` → one cycle of stall_id=1 and bubble_ex=1. The next cycle gives fwd_a=2 with no stall; hz_cnt=1. With LD_LAT=3, the same sequence stalls 3 cycles and then gives fwd_a=4.
- `addi x0,x0,5` followed by `add x6,x0,x0` → fwd 0, no stall. A dependent branch while a load is in slot 1 with redirect=1 → hazard wins and flush_fe=0.
- A load in MEM with dmem_busy held 3 cycles → stall_if/pd/id/be=1 for exactly 3 cycles; fwd selects stay stable and hz_cnt is unchanged.
- FWD_EN=0, LD_LAT=1; `add x5`, then an immediate use of x5 → stall for 3 cycles (D=3), then fwd_a=0 and the pipeline advances; hz_cnt=3.

Source files
------------

// File: rtl/hazard_ctl_if.sv
// Decode-stage view of the hazard controller: ID instruction and pipeline status in,
// per-stage stall/bubble/flush controls, forwarding selects and hazard count out.
interface hazard_ctl_if #(
    parameter int FWD_W = 2,
    parameter int CNT_W = 32
);
    logic [31:0]      id_ir;
    logic             id_valid;
    logic             imem_busy;
    logic             dmem_busy;
    logic             redirect;
    logic             stall_if;
    logic             stall_pd;
    logic             stall_id;
    logic             stall_be;
    logic             bubble_pd;
    logic             bubble_ex;
    logic             flush_fe;
    logic [FWD_W-1:0] fwd_a;
    logic [FWD_W-1:0] fwd_b;
    logic [CNT_W-1:0] hz_cnt;

    modport master (
        output id_ir, id_valid, imem_busy, dmem_busy, redirect,
        input  stall_if, stall_pd, stall_id, stall_be, bubble_pd, bubble_ex, flush_fe,
        input  fwd_a, fwd_b, hz_cnt
    );

    modport slave (
        input  id_ir, id_valid, imem_busy, dmem_busy, redirect,
        output stall_if, stall_pd, stall_id, stall_be, bubble_pd, bubble_ex, flush_fe,
        output fwd_a, fwd_b, hz_cnt
    );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard, forwarding and stall controller for the in-order RV64I hart. A shadow pipeline of
// destination records (EX, LD_LAT memory stages, WB) drives operand bypass and stall arbitration.
module hazard_ctl #(
    parameter int LD_LAT = 1,
    parameter int FWD_EN = 1,
    parameter int FWD_W  = $clog2(LD_LAT + 3),
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctl_if.slave  hz_if
);
    localparam int D = LD_LAT + 2;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef struct packed {
        logic       use1;
        logic       use2;
        logic       wen;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    typedef enum logic [2:0] {
        M_RESET = 3'd0,
        M_DMEM  = 3'd1,
        M_HAZ   = 3'd2,
        M_REDIR = 3'd3,
        M_IMEM  = 3'd4,
        M_RUN   = 3'd5
    } mode_e;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        logic wr;
        d.rs1     = ir[19:15];
        d.rs2     = ir[24:20];
        d.rd      = ir[11:7];
        d.use1    = 1'b0;
        d.use2    = 1'b0;
        d.is_load = 1'b0;
        wr        = 1'b0;
        case (ir[6:0])
            OPC_OP, OPC_OP_32: begin
                d.use1 = 1'b1;
                d.use2 = 1'b1;
                wr     = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
                d.use1 = 1'b1;
                wr     = 1'b1;
            end
            OPC_LOAD: begin
                d.use1    = 1'b1;
                d.is_load = 1'b1;
                wr        = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                d.use1 = 1'b1;
                d.use2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wr = 1'b1;
            end
            default: begin
                wr = 1'b0;
            end
        endcase
        // x0 is never a real destination, so it must not be recorded as a writer
        d.wen = wr & (d.rd != 5'd0);
        return d;
    endfunction

    function automatic logic slot_hit(input slot_t s, input logic used, input logic [4:0] rs);
        return used && (rs != 5'd0) && s.valid && s.wen && (s.rd == rs);
    endfunction

    // A matching producer whose value is not yet available must stall instead of bypass
    function automatic logic slot_blocks(input slot_t s, input int k);
        return (FWD_EN == 0) || (s.is_load && (k <= LD_LAT));
    endfunction

    slot_t            shadow_q [1:D];
    slot_t            shadow_d [1:D];
    logic [CNT_W-1:0] hz_cnt_q;
    logic [CNT_W-1:0] hz_cnt_d;

    dec_t             dec_s;
    logic             src_use_s [2];
    logic [4:0]       src_rs_s  [2];
    logic             haz_src_s [2];
    logic [FWD_W-1:0] sel_s     [2];
    logic             hazard_s;
    mode_e            mode_s;

    logic             stall_if_s;
    logic             stall_pd_s;
    logic             stall_id_s;
    logic             stall_be_s;
    logic             bubble_pd_s;
    logic             bubble_ex_s;
    logic             flush_fe_s;

    // Operand match search; scanning oldest to youngest lets the smallest slot win
    always_comb begin
        dec_s        = decode(hz_if.id_ir);
        src_use_s[0] = dec_s.use1;
        src_use_s[1] = dec_s.use2;
        src_rs_s[0]  = dec_s.rs1;
        src_rs_s[1]  = dec_s.rs2;
        for (int j = 0; j < 2; j++) begin
            haz_src_s[j] = 1'b0;
            sel_s[j]     = {FWD_W{1'b0}};
            for (int k = D; k >= 1; k--) begin
                haz_src_s[j] = slot_hit(shadow_q[k], src_use_s[j], src_rs_s[j]) ?
                               slot_blocks(shadow_q[k], k) : haz_src_s[j];
                sel_s[j]     = slot_hit(shadow_q[k], src_use_s[j], src_rs_s[j]) ?
                               (slot_blocks(shadow_q[k], k) ? {FWD_W{1'b0}} : FWD_W'(k)) :
                               sel_s[j];
            end
        end
        hazard_s = hz_if.id_valid & (haz_src_s[0] | haz_src_s[1]);
    end

    // Stall-source priority: reset, data miss, hazard, redirect, instruction miss
    always_comb begin
        if (!rst_n) begin
            mode_s = M_RESET;
        end else if (hz_if.dmem_busy) begin
            mode_s = M_DMEM;
        end else if (hazard_s) begin
            mode_s = M_HAZ;
        end else if (hz_if.redirect) begin
            mode_s = M_REDIR;
        end else if (hz_if.imem_busy) begin
            mode_s = M_IMEM;
        end else begin
            mode_s = M_RUN;
        end
    end

    // Per-stage hold, bubble and flush controls for the selected mode
    always_comb begin
        stall_if_s  = 1'b0;
        stall_pd_s  = 1'b0;
        stall_id_s  = 1'b0;
        stall_be_s  = 1'b0;
        bubble_pd_s = 1'b0;
        bubble_ex_s = 1'b0;
        flush_fe_s  = 1'b0;
        case (mode_s)
            M_DMEM: begin
                stall_if_s = 1'b1;
                stall_pd_s = 1'b1;
                stall_id_s = 1'b1;
                stall_be_s = 1'b1;
            end
            M_HAZ: begin
                stall_if_s  = 1'b1;
                stall_pd_s  = 1'b1;
                stall_id_s  = 1'b1;
                bubble_ex_s = 1'b1;
            end
            M_REDIR: begin
                flush_fe_s = 1'b1;
            end
            M_IMEM: begin
                stall_if_s  = 1'b1;
                bubble_pd_s = 1'b1;
            end
            default: begin
                stall_if_s = 1'b0;
            end
        endcase
    end

    // Shadow advance and saturating hazard counter; both freeze while the data side is busy
    always_comb begin
        shadow_d = shadow_q;
        hz_cnt_d = hz_cnt_q;
        if (mode_s != M_DMEM) begin
            shadow_d[1].valid   = hz_if.id_valid & ~hazard_s;
            shadow_d[1].wen     = dec_s.wen;
            shadow_d[1].rd      = dec_s.rd;
            shadow_d[1].is_load = dec_s.is_load;
            for (int k = 2; k <= D; k++) begin
                shadow_d[k] = shadow_q[k-1];
            end
        end else begin
            shadow_d = shadow_q;
        end
        if ((mode_s == M_HAZ) && (hz_cnt_q != {CNT_W{1'b1}})) begin
            hz_cnt_d = hz_cnt_q + CNT_W'(1);
        end else begin
            hz_cnt_d = hz_cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= D; k++) begin
                shadow_q[k] <= '0;
            end
            hz_cnt_q <= {CNT_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            hz_cnt_q <= hz_cnt_d;
        end
    end

    assign hz_if.stall_if  = stall_if_s;
    assign hz_if.stall_pd  = stall_pd_s;
    assign hz_if.stall_id  = stall_id_s;
    assign hz_if.stall_be  = stall_be_s;
    assign hz_if.bubble_pd = bubble_pd_s;
    assign hz_if.bubble_ex = bubble_ex_s;
    assign hz_if.flush_fe  = flush_fe_s;
    assign hz_if.fwd_a     = (mode_s == M_RESET) ? {FWD_W{1'b0}} : sel_s[0];
    assign hz_if.fwd_b     = (mode_s == M_RESET) ? {FWD_W{1'b0}} : sel_s[1];
    assign hz_if.hz_cnt    = hz_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: three configurations (bypass LD_LAT=1, bypass LD_LAT=3,
// no-bypass with a 2-bit counter) driven with hand-encoded instruction sequences.
module tb_hazard_ctl;
    localparam logic [31:0] NOP    = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] ADD5   = 32'h002082B3; // add  x5,x1,x2
    localparam logic [31:0] SUB6   = 32'h40528333; // sub  x6,x5,x5
    localparam logic [31:0] OR7    = 32'h0002E3B3; // or   x7,x5,x0
    localparam logic [31:0] LD5    = 32'h0000B283; // ld   x5,0(x1)
    localparam logic [31:0] ADD6   = 32'h00128333; // add  x6,x5,x1
    localparam logic [31:0] ADDI0  = 32'h00500013; // addi x0,x0,5
    localparam logic [31:0] ADD600 = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] BEQ5   = 32'h00028063; // beq  x5,x0,0
    localparam logic [31:0] ADD6X7 = 32'h00038333; // add  x6,x7,x0

    // {stall_if, stall_pd, stall_id, stall_be, bubble_pd, bubble_ex, flush_fe}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_HAZ   = 7'b1110010;
    localparam logic [6:0] C_DMEM  = 7'b1111000;
    localparam logic [6:0] C_REDIR = 7'b0000001;
    localparam logic [6:0] C_IMEM  = 7'b1000100;

    typedef struct {
        int         tag;
        logic [6:0] ctl;
        int         fa;
        int         fb;
        int         hz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir_v  [3];
    logic        val_v [3];
    logic        im_v  [3];
    logic        dm_v  [3];
    logic        rd_v  [3];
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          tag    = 0;

    always #5 clk = ~clk;

    hazard_ctl_if #(.FWD_W(2), .CNT_W(32)) if0 ();
    hazard_ctl_if #(.FWD_W(3), .CNT_W(32)) if1 ();
    hazard_ctl_if #(.FWD_W(2), .CNT_W(2))  if2 ();

    assign if0.id_ir = ir_v[0];  assign if0.id_valid = val_v[0];  assign if0.imem_busy = im_v[0];
    assign if0.dmem_busy = dm_v[0];  assign if0.redirect = rd_v[0];
    assign if1.id_ir = ir_v[1];  assign if1.id_valid = val_v[1];  assign if1.imem_busy = im_v[1];
    assign if1.dmem_busy = dm_v[1];  assign if1.redirect = rd_v[1];
    assign if2.id_ir = ir_v[2];  assign if2.id_valid = val_v[2];  assign if2.imem_busy = im_v[2];
    assign if2.dmem_busy = dm_v[2];  assign if2.redirect = rd_v[2];

    hazard_ctl #(.LD_LAT(1), .FWD_EN(1), .FWD_W(2), .CNT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .hz_if(if0));
    hazard_ctl #(.LD_LAT(3), .FWD_EN(1), .FWD_W(3), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .hz_if(if1));
    hazard_ctl #(.LD_LAT(1), .FWD_EN(0), .FWD_W(2), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .hz_if(if2));

    task automatic check(input int d, input exp_t e, input logic [6:0] ctl, input int fa, input int fb, input int hz);
        n_vec++;
        if (ctl !== e.ctl || fa != e.fa || fb != e.fb || hz != e.hz) begin
            n_fail++;
            $display("FAIL dut%0d vec%0d: got ctl=%b fwd_a=%0d fwd_b=%0d hz_cnt=%0d, want ctl=%b fwd_a=%0d fwd_b=%0d hz_cnt=%0d",
                     d, e.tag, ctl, fa, fb, hz, e.ctl, e.fa, e.fb, e.hz);
        end
    endtask

    // Drive one cycle on DUT d (others idle on NOP) and queue what it must show this cycle
    task automatic step(input int d, input logic [31:0] ir, input logic v, input logic im, input logic dm,
                        input logic rd, input logic [6:0] ctl, input int fa, input int fb, input int hz);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            ir_v[i] = NOP; val_v[i] = 1'b1; im_v[i] = 1'b0; dm_v[i] = 1'b0; rd_v[i] = 1'b0;
        end
        ir_v[d] = ir; val_v[d] = v; im_v[d] = im; dm_v[d] = dm; rd_v[d] = rd;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.hz = hz;
        tag++;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, e, {if0.stall_if, if0.stall_pd, if0.stall_id, if0.stall_be, if0.bubble_pd, if0.bubble_ex,
                         if0.flush_fe}, int'(if0.fwd_a), int'(if0.fwd_b), int'(if0.hz_cnt));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, e, {if1.stall_if, if1.stall_pd, if1.stall_id, if1.stall_be, if1.bubble_pd, if1.bubble_ex,
                         if1.flush_fe}, int'(if1.fwd_a), int'(if1.fwd_b), int'(if1.hz_cnt));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check(2, e, {if2.stall_if, if2.stall_pd, if2.stall_id, if2.stall_be, if2.bubble_pd, if2.bubble_ex,
                         if2.flush_fe}, int'(if2.fwd_a), int'(if2.fwd_b), int'(if2.hz_cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at time %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ir_v[i] = NOP; val_v[i] = 1'b1; im_v[i] = 1'b0; dm_v[i] = 1'b0; rd_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        // reset holds everything quiet, even with a data miss pending
        step(0, NOP,    1'b1, 1'b0, 1'b1, 1'b0, C_NONE, 0, 0, 0);
        rst_n = 1'b1;

        // LD_LAT=1 with bypass
        step(0, NOP,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 0);
        step(0, ADD5,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 0);
        step(0, SUB6,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  1, 1, 0);
        step(0, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  2, 0, 0);
        step(0, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 0);
        step(0, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 0);
        step(0, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  2, 0, 1);
        step(0, ADDI0,  1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 1);
        step(0, ADD600, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 1);
        step(0, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 1);
        step(0, BEQ5,   1'b1, 1'b0, 1'b0, 1'b1, C_HAZ,   0, 0, 1);
        step(0, BEQ5,   1'b1, 1'b0, 1'b0, 1'b1, C_REDIR, 2, 0, 2);
        step(0, NOP,    1'b1, 1'b1, 1'b0, 1'b0, C_IMEM,  0, 0, 2);
        step(0, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 2);
        step(0, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 2);
        step(0, OR7,    1'b1, 1'b0, 1'b1, 1'b0, C_DMEM,  2, 0, 3);
        step(0, OR7,    1'b1, 1'b0, 1'b1, 1'b0, C_DMEM,  2, 0, 3);
        step(0, OR7,    1'b1, 1'b0, 1'b1, 1'b0, C_DMEM,  2, 0, 3);
        step(0, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  2, 0, 3);
        step(0, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);
        step(0, ADD6,   1'b1, 1'b0, 1'b1, 1'b0, C_DMEM,  0, 0, 3);
        step(0, ADD6,   1'b1, 1'b0, 1'b1, 1'b0, C_DMEM,  0, 0, 3);
        step(0, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 3);
        step(0, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  2, 0, 4);
        step(0, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 4);
        step(0, ADD6,   1'b0, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 4);
        step(0, NOP,    1'b1, 1'b1, 1'b0, 1'b1, C_REDIR, 0, 0, 4);

        // LD_LAT=3 with bypass: 3-cycle load-use, youngest-writer and WB-slot forwarding
        step(1, LD5,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 0);
        step(1, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 0);
        step(1, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 1);
        step(1, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 2);
        step(1, ADD6,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  4, 0, 3);
        step(1, ADD5,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);
        step(1, ADD5,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);
        step(1, SUB6,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  1, 1, 3);
        step(1, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  2, 0, 3);
        step(1, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  3, 0, 3);
        step(1, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  4, 0, 3);
        step(1, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  5, 0, 3);
        step(1, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);

        // no bypass, 2-bit counter: D=3 stall cycles per dependence, counter saturates at 3
        step(2, ADD5,   1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 0);
        step(2, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 0);
        step(2, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 1);
        step(2, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 2);
        step(2, OR7,    1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);
        step(2, ADD6X7, 1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 3);
        step(2, ADD6X7, 1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 3);
        step(2, ADD6X7, 1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,   0, 0, 3);
        step(2, ADD6X7, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  0, 0, 3);

        @(negedge clk);
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q0.size() + q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
